// File: rtl/if_fetch_ctrl.sv
// Fetch-stage sequencing controller: next-PC source arbitration, load-use stalls, imem wait states.
// Optional performance counters are enabled with `define IF_FETCH_CTRL_PERF_EN.
module if_fetch_ctrl #(
  parameter int unsigned BOOT_HOLD = 2,
  parameter int unsigned LU_CYCLES = 1
`ifdef IF_FETCH_CTRL_PERF_EN
  ,
  parameter int unsigned CNT_W     = 16
`endif
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       stall_req,
  input  logic       br_taken,
  input  logic       jmp_req,
  input  logic       trap_req,
  input  logic       imem_ready,
  output logic [1:0] pcsource,
  output logic       pc_we,
  output logic       if_flush,
  output logic       id_stall,
  output logic       fetch_req,
  output logic [1:0] fsm_state
`ifdef IF_FETCH_CTRL_PERF_EN
  ,
  input  logic             perf_clr,
  output logic [CNT_W-1:0] redirect_cnt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] wait_cnt
`endif
);

  localparam int unsigned BOOT_W = 4;
  localparam int unsigned LU_W   = 3;

  typedef enum logic [1:0] {
    S_BOOT  = 2'b00,
    S_FETCH = 2'b01,
    S_STALL = 2'b10,
    S_WAIT  = 2'b11
  } state_e;

  state_e            state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q, boot_cnt_d;
  logic [LU_W-1:0]   lu_cnt_q, lu_cnt_d;
  logic [1:0]        redir_sel;

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q    <= S_BOOT;
      boot_cnt_q <= '0;
      lu_cnt_q   <= '0;
    end else begin
      state_q    <= state_d;
      boot_cnt_q <= boot_cnt_d;
      lu_cnt_q   <= lu_cnt_d;
    end
  end

  // Highest-priority redirect source; 00 means no redirect requested.
  always_comb begin
    if (trap_req)      redir_sel = 2'b11;
    else if (jmp_req)  redir_sel = 2'b10;
    else if (br_taken) redir_sel = 2'b01;
    else               redir_sel = 2'b00;
  end

  // Next state and Mealy controls; a redirect acts in the cycle it is requested.
  always_comb begin
    state_d    = state_q;
    boot_cnt_d = boot_cnt_q;
    lu_cnt_d   = lu_cnt_q;
    pcsource   = 2'b00;
    pc_we      = 1'b0;
    if_flush   = 1'b1;
    id_stall   = 1'b0;
    fetch_req  = 1'b0;
    unique case (state_q)
      S_BOOT: begin
        if (boot_cnt_q == BOOT_W'(BOOT_HOLD - 1)) begin
          boot_cnt_d = '0;
          state_d    = S_FETCH;
        end else begin
          boot_cnt_d = boot_cnt_q + BOOT_W'(1);
        end
      end
      S_FETCH: begin
        fetch_req = 1'b1;
        if (redir_sel != 2'b00) begin
          pcsource = redir_sel;
          pc_we    = 1'b1;
        end else if (stall_req) begin
          id_stall = 1'b1;
          if_flush = 1'b0;
          lu_cnt_d = LU_W'(LU_CYCLES - 1);
          if (LU_CYCLES > 1) state_d = S_STALL;
        end else if (imem_ready) begin
          pc_we    = 1'b1;
          if_flush = 1'b0;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_STALL: begin
        // Only a trap can break a stall; branches/jumps re-present afterwards.
        if (trap_req) begin
          pcsource = 2'b11;
          pc_we    = 1'b1;
          lu_cnt_d = '0;
          state_d  = S_FETCH;
        end else begin
          id_stall = 1'b1;
          if_flush = 1'b0;
          if (lu_cnt_q <= LU_W'(1)) begin
            lu_cnt_d = '0;
            state_d  = S_FETCH;
          end else begin
            lu_cnt_d = lu_cnt_q - LU_W'(1);
          end
        end
      end
      S_WAIT: begin
        fetch_req = 1'b1;
        if (redir_sel != 2'b00) begin
          pcsource = redir_sel;
          pc_we    = 1'b1;
          state_d  = S_FETCH;
        end else if (imem_ready) begin
          pc_we    = 1'b1;
          if_flush = 1'b0;
          state_d  = S_FETCH;
        end
      end
      default: state_d = S_BOOT;
    endcase
  end

  assign fsm_state = state_q;

`ifdef IF_FETCH_CTRL_PERF_EN
  logic [CNT_W-1:0] redirect_cnt_q, redirect_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic             redirect_evt, stall_evt, wait_evt;

  assign redirect_evt = pc_we && (pcsource != 2'b00);
  assign stall_evt    = id_stall;
  assign wait_evt     = (state_q == S_WAIT);

  // Saturating event counters; perf_clr wins over increment.
  always_comb begin
    redirect_cnt_d = redirect_cnt_q;
    stall_cnt_d    = stall_cnt_q;
    wait_cnt_d     = wait_cnt_q;
    if (perf_clr) begin
      redirect_cnt_d = '0;
      stall_cnt_d    = '0;
      wait_cnt_d     = '0;
    end else begin
      if (redirect_evt && (redirect_cnt_q != '1)) redirect_cnt_d = redirect_cnt_q + CNT_W'(1);
      if (stall_evt && (stall_cnt_q != '1))       stall_cnt_d    = stall_cnt_q + CNT_W'(1);
      if (wait_evt && (wait_cnt_q != '1))         wait_cnt_d     = wait_cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      redirect_cnt_q <= '0;
      stall_cnt_q    <= '0;
      wait_cnt_q     <= '0;
    end else begin
      redirect_cnt_q <= redirect_cnt_d;
      stall_cnt_q    <= stall_cnt_d;
      wait_cnt_q     <= wait_cnt_d;
    end
  end

  assign redirect_cnt = redirect_cnt_q;
  assign stall_cnt    = stall_cnt_q;
  assign wait_cnt     = wait_cnt_q;
`endif

endmodule

// File: tb/tb_if_fetch_ctrl.sv
// Directed bench for if_fetch_ctrl (BOOT_HOLD=2, LU_CYCLES=3).
module tb_if_fetch_ctrl;

  logic       clk;
  logic       clrn;
  logic       stall_req, br_taken, jmp_req, trap_req, imem_ready;
  logic [1:0] pcsource;
  logic       pc_we, if_flush, id_stall, fetch_req;
  logic [1:0] fsm_state;
`ifdef IF_FETCH_CTRL_PERF_EN
  logic        perf_clr;
  logic [15:0] redirect_cnt, stall_cnt, wait_cnt;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Packed observation: {pcsource, pc_we, if_flush, id_stall, fetch_req, fsm_state}
  localparam logic [7:0] V_BOOT     = 8'b00_0_1_0_0_00;
  localparam logic [7:0] V_RUN      = 8'b00_1_0_0_1_01;
  localparam logic [7:0] V_JMP_F    = 8'b10_1_1_0_1_01;
  localparam logic [7:0] V_TRAP_F   = 8'b11_1_1_0_1_01;
  localparam logic [7:0] V_STALL_E  = 8'b00_0_0_1_1_01;
  localparam logic [7:0] V_STALL    = 8'b00_0_0_1_0_10;
  localparam logic [7:0] V_TRAP_S   = 8'b11_1_1_0_0_10;
  localparam logic [7:0] V_WAIT_E   = 8'b00_0_1_0_1_01;
  localparam logic [7:0] V_WAIT     = 8'b00_0_1_0_1_11;
  localparam logic [7:0] V_WAIT_RDY = 8'b00_1_0_0_1_11;
  localparam logic [7:0] V_JMP_W    = 8'b10_1_1_0_1_11;

  if_fetch_ctrl #(
    .BOOT_HOLD(2),
    .LU_CYCLES(3)
  ) dut (
    .clk       (clk),
    .clrn      (clrn),
    .stall_req (stall_req),
    .br_taken  (br_taken),
    .jmp_req   (jmp_req),
    .trap_req  (trap_req),
    .imem_ready(imem_ready),
    .pcsource  (pcsource),
    .pc_we     (pc_we),
    .if_flush  (if_flush),
    .id_stall  (id_stall),
    .fetch_req (fetch_req),
    .fsm_state (fsm_state)
`ifdef IF_FETCH_CTRL_PERF_EN
    ,
    .perf_clr    (perf_clr),
    .redirect_cnt(redirect_cnt),
    .stall_cnt   (stall_cnt),
    .wait_cnt    (wait_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] obs();
    return {pcsource, pc_we, if_flush, id_stall, fetch_req, fsm_state};
  endfunction

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_assert++;
    assert (o === e) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  // Advance one cycle, apply inputs, then sample mid-cycle.
  task automatic step(input logic tr, input logic jr, input logic br,
                      input logic sr, input logic rdy);
    @(posedge clk);
    #1;
    trap_req = tr; jmp_req = jr; br_taken = br; stall_req = sr; imem_ready = rdy;
    #2;
  endtask

  // Structural invariants, checked every cycle outside reset.
  always @(negedge clk) begin
    if (clrn) begin
      n_assert++;
      assert (!(pc_we && id_stall) && !(pc_we && pcsource != 2'b00 && !if_flush)) else begin
        n_fail++;
        $error("FAIL invariant: pc_we=%0b id_stall=%0b pcsource=%0b if_flush=%0b",
               pc_we, id_stall, pcsource, if_flush);
      end
    end
  end

  initial begin
    clrn = 1'b0;
    stall_req = 1'b0; br_taken = 1'b0; jmp_req = 1'b0; trap_req = 1'b0; imem_ready = 1'b1;
`ifdef IF_FETCH_CTRL_PERF_EN
    perf_clr = 1'b0;
`endif
    #3;
    chk("reset", 32'(obs()), 32'(V_BOOT));

    // Boot hold: two cycles without fetch, trap ignored in the second
    @(posedge clk); #1; clrn = 1'b1; #2;
    chk("boot1", 32'(obs()), 32'(V_BOOT));
    step(1, 0, 0, 0, 1); chk("boot2_trap_ign", 32'(obs()), 32'(V_BOOT));
    step(0, 0, 0, 0, 1); chk("fetch1", 32'(obs()), 32'(V_RUN));
    step(0, 0, 0, 0, 1); chk("fetch2", 32'(obs()), 32'(V_RUN));

    // Jump beats branch; trap beats jump
    step(0, 1, 1, 0, 1); chk("jmp_over_br", 32'(obs()), 32'(V_JMP_F));
    step(0, 0, 0, 0, 1); chk("after_jmp", 32'(obs()), 32'(V_RUN));
    step(1, 1, 1, 1, 0); chk("trap_over_all", 32'(obs()), 32'(V_TRAP_F));
    step(0, 0, 0, 0, 1); chk("after_trap", 32'(obs()), 32'(V_RUN));

    // Load-use stall of 3 cycles, branch masked in cycles 2-3
    step(0, 0, 0, 1, 1); chk("stall_c1", 32'(obs()), 32'(V_STALL_E));
    step(0, 0, 1, 0, 1); chk("stall_c2_br_mask", 32'(obs()), 32'(V_STALL));
    step(0, 0, 1, 1, 1); chk("stall_c3_br_mask", 32'(obs()), 32'(V_STALL));
    step(0, 0, 0, 0, 1); chk("stall_resume", 32'(obs()), 32'(V_RUN));

    // Trap aborts the stall in its second cycle
    step(0, 0, 0, 1, 1); chk("stall2_c1", 32'(obs()), 32'(V_STALL_E));
    step(1, 0, 0, 0, 1); chk("stall2_trap", 32'(obs()), 32'(V_TRAP_S));
    step(0, 0, 0, 0, 1); chk("stall2_aborted", 32'(obs()), 32'(V_RUN));

    // Memory wait for 3 cycles, then ready
    step(0, 0, 0, 0, 0); chk("wait_entry", 32'(obs()), 32'(V_WAIT_E));
    step(0, 0, 0, 0, 0); chk("wait_c2", 32'(obs()), 32'(V_WAIT));
    step(0, 0, 0, 0, 0); chk("wait_c3", 32'(obs()), 32'(V_WAIT));
    step(0, 0, 0, 0, 1); chk("wait_ready", 32'(obs()), 32'(V_WAIT_RDY));
    step(0, 0, 0, 0, 1); chk("wait_done", 32'(obs()), 32'(V_RUN));

    // Jump overrides a pending wait
    step(0, 0, 0, 0, 0); chk("wait2_entry", 32'(obs()), 32'(V_WAIT_E));
    step(0, 1, 0, 0, 0); chk("wait2_jmp", 32'(obs()), 32'(V_JMP_W));
    step(0, 0, 0, 0, 1); chk("wait2_after_jmp", 32'(obs()), 32'(V_RUN));

    // stall_req ignored in WAIT
    step(0, 0, 0, 0, 0); chk("wait3_entry", 32'(obs()), 32'(V_WAIT_E));
    step(0, 0, 0, 1, 0); chk("wait3_stall_ign", 32'(obs()), 32'(V_WAIT));
    step(0, 0, 0, 0, 0); chk("wait3_still", 32'(obs()), 32'(V_WAIT));

    // Asynchronous reset between edges while in WAIT
    #1; clrn = 1'b0; #1;
    chk("async_reset", 32'(obs()), 32'(V_BOOT));
`ifdef IF_FETCH_CTRL_PERF_EN
    chk("perf_redirect_clr", 32'(redirect_cnt), 32'd0);
    chk("perf_stall_clr", 32'(stall_cnt), 32'd0);
    chk("perf_wait_clr", 32'(wait_cnt), 32'd0);
`endif
    imem_ready = 1'b1;
    @(posedge clk); #1; clrn = 1'b1; #2;
    chk("reboot1", 32'(obs()), 32'(V_BOOT));
    step(0, 0, 0, 0, 1); chk("reboot2", 32'(obs()), 32'(V_BOOT));
    step(0, 0, 0, 0, 1); chk("refetch", 32'(obs()), 32'(V_RUN));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
